ps2_rx_fifo: RTL
================

// Module: ps2_rx_fifo
// PURPOSE
//  Parametrised PS/2 receive controller for the picoVersat calculator; supersedes the raw PS2_CLK/PS2_DATA pins of xtop.
//  Samples the keyboard line, checks odd parity, start bit and stop bit, and buffers scan codes in a FIFO.
//  Exposes the FIFO and status on a peripheral register port for picoVersat firmware.
// PARAMETERS
//  DATA_W       32    peripheral data width (= `DATA_W); must be >= 16
//  FIFO_DEPTH   8     scan-code entries; power of 2, >= 2
//  SYNC_STAGES  2     synchroniser flops on ps2_clk/ps2_data; >= 2
//  TIMEOUT_CYC  5000  idle clk cycles before a partial frame is aborted (PS2_TIMEOUT_EN only)
// PORTS
//  clk       in   1       system clock
//  rst       in   1       synchronous, active-high reset
//  ps2_clk   in   1       PS/2 clock from device, asynchronous
//  ps2_data  in   1       PS/2 data from device, asynchronous
//  sel       in   1       peripheral select
//  we        in   1       write enable (valid with sel)
//  addr      in   2       register address
//  data_in   in   DATA_W  write data
//  data_out  out  DATA_W  read data, combinational from addr
//  irq       out  1       FIFO non-empty
//  err       out  1       OR of the sticky error flags
// BEHAVIOUR
//  Reset: FSM=IDLE; FIFO empty; all sticky flags 0; irq=0; err=0; data_out=0 when sel=0.
//  Sync: ps2_clk and ps2_data each pass through SYNC_STAGES flops. A falling edge is a synced-clk 1->0, seen as one cycle.
//  FSM (advances on falling edge only):
//   - IDLE:   data=0 -> DATA (bit count 0); data=1 -> stay (glitch).
//   - DATA:   shift in LSB first; after the 8th bit -> PARITY.
//   - PARITY: capture bit -> STOP.
//   - STOP:   -> IDLE always.
//  Frame check on STOP sample (cycle N):
//   - parity bad (XOR of data+parity != 1) -> set par_err, drop byte.
//   - else stop=0 -> set frm_err, drop byte.
//   - else push on cycle N+1; count/irq update on N+2.
//  FIFO full at push -> byte dropped, set ovf. A pop in the same cycle frees a slot first, so no overflow.
//  Register map:
//   - addr 0, read: {.., valid[8], code[7:0]}. With sel & !we and FIFO non-empty: valid=1 and pop this cycle.
//     If empty: returns 0, no state change.
//   - addr 1, read: {.., count[$clog2(FIFO_DEPTH):0] at [8+:], frm_err[4], ovf[3], par_err[2], full[1], empty[0]}. No side effects.
//   - addr 2, write: bit0=1 clears sticky flags; bit1=1 flushes FIFO.
//     If a push and a flush coincide, the flush wins.
//   - addr 3: reads 0; writes ignored.
//  Wrap-around: pointers are log2(FIFO_DEPTH)+1 bits; full/empty are decided by the MSB.
//  Reset mid-frame: partial byte discarded; FSM returns to IDLE.
// CONFIGURATION
//  `PS2_TIMEOUT_EN defined:
//   - Counter clears on every falling edge and counts while FSM != IDLE.
//   - At TIMEOUT_CYC: FSM -> IDLE, partial byte discarded, set frm_err.
//  Not defined: no counter; the FSM waits indefinitely for the next edge.
// STRUCTURE
//  ps2_defs.vh (shared header, included with xdefs.vh):
//   - register addresses PS2_ADDR_DATA/STAT/CTRL
//   - status bit indices
//   - FSM state encodings (2 bits)
//  Sub-module ps2_sync_fifo: parametrised width 8 / depth FIFO_DEPTH; push/pop/flush; count, full, empty outputs.
// TESTING
//  1. Send frame 0x1C with good parity and stop -> irq=1; addr0 read = 0x11C; next addr0 read = 0x000.
//  2. Send 0x5A with wrong parity -> par_err=1, err=1, FIFO empty.
//     Write addr2=1 -> err=0.
//  3. Send FIFO_DEPTH+1 codes with no reads -> full=1, ovf=1, count=8. Reads return the first 8 codes in order.
//  4. Fill FIFO, then read addr0 on the STOP+1 cycle of a 9th frame -> ovf=0, count stays 8.
//  5. Assert rst after 4 data bits; send 0x29 -> only 0x29 is read back.
//  6. With PS2_TIMEOUT_EN: stop ps2_clk after 5 bits for TIMEOUT_CYC cycles -> frm_err=1, FSM=IDLE.
//     A following 0x16 frame is received correctly.

Source files
------------

// File: rtl/ps2_rx_fifo_pkg.sv
// ps2_rx_fifo_pkg: shared definitions for the PS/2 receive controller.
// Register addresses, status/control bit indices and FSM state encoding.
package ps2_rx_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [1:0] PS2_ADDR_DATA = 2'd0;
  localparam logic [1:0] PS2_ADDR_STAT = 2'd1;
  localparam logic [1:0] PS2_ADDR_CTRL = 2'd2;
  localparam logic [1:0] PS2_ADDR_RSVD = 2'd3;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_PAR_ERR = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_FRM_ERR = 4;
  localparam int STAT_CNT     = 8;

  localparam int DATA_VALID   = 8;

  localparam int CTRL_CLR     = 0;
  localparam int CTRL_FLUSH   = 1;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// ps2_sync_fifo: single-clock FIFO with extra-MSB pointers for full/empty.
// A pop in the same cycle as a push on a full FIFO frees the slot first.
// Flush empties the FIFO and overrides any push/pop in the same cycle.
module ps2_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty,
  output logic         overflow
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         do_push, do_pop;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count    = wptr - rptr;
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & ~flush & full & ~do_pop;
  assign rdata    = mem[rptr[AW-1:0]];

  // Pointer update; flush and reset both return to empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write, no reset needed on the array.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver with scan-code FIFO and register port.
// Optional build macro PS2_TIMEOUT_EN aborts a stalled partial frame after
// TIMEOUT_CYC idle cycles and flags it as a framing error.
module ps2_rx_fifo
  import ps2_rx_fifo_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              irq,
  output logic              err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_s, dat_s, clk_prev, fall;

  ps2_state_e state, state_nxt;
  logic [2:0] bcnt, bcnt_nxt;
  logic [7:0] shreg, shreg_nxt, code_q;
  logic       par_bit, par_nxt;
  logic       push_q, push_nxt;
  logic       set_par, set_frm, timeout;

  logic       par_err, frm_err, ovf;
  logic       pop, flush, clr;
  logic [7:0] rdata;
  logic [AW:0] count;
  logic       full, empty, fifo_ovf;
  logic       unused_data;

  // Line synchronisers; reset to the idle-high level so no false edge appears.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_s;
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];
  assign fall  = clk_prev & ~clk_s;

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;

  // Idle timer: restarts on each falling edge, runs only mid-frame.
  always_ff @(posedge clk) begin
    if (rst || fall || state == ST_IDLE) to_cnt <= '0;
    else                                 to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = (state != ST_IDLE) && (to_cnt == TW'(TIMEOUT_CYC));
`else
  logic unused_to;
  assign unused_to = (TIMEOUT_CYC > 0);
  assign timeout   = 1'b0;
`endif

  // Frame FSM registers plus the one-cycle push stage after the STOP sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      bcnt    <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      push_q  <= 1'b0;
      code_q  <= '0;
    end else begin
      state   <= state_nxt;
      bcnt    <= bcnt_nxt;
      shreg   <= shreg_nxt;
      par_bit <= par_nxt;
      push_q  <= push_nxt;
      if (push_nxt) code_q <= shreg;
    end
  end

  // Next-state: advance only on a falling PS/2 clock edge; check frame at STOP.
  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    shreg_nxt = shreg;
    par_nxt   = par_bit;
    push_nxt  = 1'b0;
    set_par   = 1'b0;
    set_frm   = 1'b0;
    if (fall) begin
      case (state)
        ST_IDLE: begin
          if (!dat_s) begin
            state_nxt = ST_DATA;
            bcnt_nxt  = '0;
          end
        end
        ST_DATA: begin
          shreg_nxt = {dat_s, shreg[7:1]};
          bcnt_nxt  = bcnt + 3'd1;
          if (bcnt == 3'd7) state_nxt = ST_PARITY;
        end
        ST_PARITY: begin
          par_nxt   = dat_s;
          state_nxt = ST_STOP;
        end
        ST_STOP: begin
          state_nxt = ST_IDLE;
          if (!odd_parity_ok(shreg, par_bit)) set_par  = 1'b1;
          else if (!dat_s)                    set_frm  = 1'b1;
          else                                push_nxt = 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_nxt = ST_IDLE;
      set_frm   = 1'b1;
    end
  end

  assign pop   = sel & ~we & (addr == PS2_ADDR_DATA) & ~empty;
  assign flush = sel & we & (addr == PS2_ADDR_CTRL) & data_in[CTRL_FLUSH];
  assign clr   = sel & we & (addr == PS2_ADDR_CTRL) & data_in[CTRL_CLR];
  assign unused_data = ^data_in[DATA_W-1:2];

  ps2_sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_q),
    .pop      (pop),
    .flush    (flush),
    .wdata    (code_q),
    .rdata    (rdata),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (fifo_ovf)
  );

  // Sticky error flags; a new event in the clearing cycle is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_err <= 1'b0;
      frm_err <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (clr) begin
        par_err <= 1'b0;
        frm_err <= 1'b0;
        ovf     <= 1'b0;
      end
      if (set_par)  par_err <= 1'b1;
      if (set_frm)  frm_err <= 1'b1;
      if (fifo_ovf) ovf     <= 1'b1;
    end
  end

  assign irq = ~empty;
  assign err = par_err | frm_err | ovf;

  // Read mux; zero whenever the block is not selected.
  always_comb begin
    data_out = '0;
    if (sel) begin
      case (addr)
        PS2_ADDR_DATA: begin
          if (!empty) begin
            data_out[7:0]       = rdata;
            data_out[DATA_VALID] = 1'b1;
          end
        end
        PS2_ADDR_STAT: begin
          data_out[STAT_CNT +: AW+1] = count;
          data_out[STAT_FRM_ERR]     = frm_err;
          data_out[STAT_OVF]         = ovf;
          data_out[STAT_PAR_ERR]     = par_err;
          data_out[STAT_FULL]        = full;
          data_out[STAT_EMPTY]       = empty;
        end
        PS2_ADDR_RSVD: data_out = '0;
        default:       data_out = '0;
      endcase
    end
  end

endmodule
